ahb_decoder_resp_mux: RTL and testbench
=======================================

// Module: ahb_decoder_resp_mux
// PURPOSE
//  Address decoder and slave-response multiplexer between the master-side address/wdata muxes and the AHB slave tops.
//  - Address phase: decodes haddr_mux_out to a one-hot hsel.
//  - Data phase: registers the selection and routes the selected slave's hrdata/hready/hresp back to the master.
//  - Built-in default slave gives the two-cycle AHB ERROR response for unmapped addresses.
//  - Optional watchdog aborts a slave that stalls too long.
// PARAMETERS
//  DW       32  data bus width
//  TIMEOUT  16  max consecutive hready-low data-phase cycles before forced ERROR; 0 = watchdog disabled
// PORTS
//  hclk           in   1      system clock; all state on rising edge
//  hreset         in   1      synchronous reset, active-high
//  haddr_mux_out  in   32     address from master address mux
//  htrans         in   2      00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hrdata_s       in   3*DW   slave read data, slave n at [n*DW +: DW]
//  hready_s       in   3      per-slave hready
//  hresp_s        in   6      per-slave hresp, slave n at [2n +: 2]
//  hsel           out  3      one-hot address-phase slave select (combinational)
//  hrdata         out  DW     read data to master
//  hready         out  1      global hready to master and all slaves
//  hresp          out  2      00 OKAY, 01 ERROR to master
// BEHAVIOUR
//  Decode (combinational, not qualified by htrans):
//  - haddr[31:30]=00 -> hsel=001; 01 -> 010; 10 -> 100; 11 -> hsel=000 (default slave).
//  Data-phase select dsel: one of {NONE, S0, S1, S2, DEF}.
//  - Loaded only on edges where hready=1.
//  - htrans[1]=1 -> dsel = decoded target; otherwise dsel = NONE.
//  - dsel holds while hready=0.
//  Output mux:
//  - S0..S2: hrdata/hready/hresp copy that slave's inputs.
//  - NONE: hrdata=0, hready=1, hresp=00.
//  - DEF: driven by error FSM, hrdata=0.
//  Error FSM {IDLE, ERR1, ERR2}:
//  - IDLE -> ERR1 when dsel is loaded with DEF, or when the watchdog fires.
//  - ERR1: hready=0, hresp=01, always -> ERR2.
//  - ERR2: hready=1, hresp=01, then -> IDLE.
//  - ERR2 is also an address-phase sampling cycle: a new valid unmapped transfer goes straight back to ERR1.
//  - While FSM is in ERR1/ERR2 it overrides the output mux regardless of dsel.
//  Watchdog:
//  - 5-bit counter wdog, cleared whenever hready=1 or dsel not in S0..S2.
//  - Increments on each cycle where the selected slave's hready=0.
//  - When wdog = TIMEOUT-1 while the slave's hready is still 0, the FSM enters ERR1 next cycle; slave outputs are ignored until ERR2 completes.
//  - Supported range: TIMEOUT <= 31.
//  Latency:
//  - Zero-wait OKAY for mapped slaves with hready_s=1.
//  - Exactly 2 cycles for the default-slave ERROR.
//  - IDLE/BUSY to any address -> OKAY, zero wait, no ERROR.
//  Reset (hreset=1 at an edge):
//  - dsel=NONE, FSM=IDLE, wdog=0.
//  - Outputs then read hready=1, hresp=00, hrdata=0.
//  - Applies even mid-ERR1 or mid slave wait state; a pending error is dropped.
//  Simultaneous events:
//  - Watchdog fire and slave hready rising in the same cycle: the slave wins, no ERROR.
//  - Slave hresp ERROR is passed through unmodified; its two-cycle rule is the slave's responsibility.
// TESTING
//  1 Reset: hreset=1 for 2 cycles during a slave1 wait state -> hready=1, hresp=00, hrdata=0 on the cycle after reset deasserts.
//  2 NONSEQ read at 0x4000_0010, hready_s[1]=1, slave1 data 0xDEADBEEF -> hsel=010 in addr phase; next cycle hrdata=0xDEADBEEF, hready=1, hresp=00.
//  3 Slave2 transfer (0x8000_0000) with hready_s[2] low 3 cycles -> hready low 3 cycles; a different haddr driven meanwhile is not sampled; dsel stays S2.
//  4 NONSEQ at 0xC000_0004 -> +1: hready=0, hresp=01; +2: hready=1, hresp=01; +3: OKAY. IDLE to 0xC000_0004 -> OKAY, zero wait.
//  5 Back-to-back unmapped NONSEQ presented in the ERR2 cycle -> ERR1 follows immediately; 4 error cycles total, no OKAY gap.
//  6 TIMEOUT=16, slave0 holds hready low 20 cycles -> ERR1 after 16th low cycle, then ERR2, then OKAY; slave-recovery-on-16th-cycle variant -> no ERROR.

Source files
------------

// File: rtl/ahb_decoder_resp_mux.sv
// AHB address decoder and slave-response multiplexer with a built-in default
// slave (two-cycle ERROR for unmapped space) and a stalled-slave watchdog.
module ahb_decoder_resp_mux #(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic [31:0]     haddr_mux_out,
    input  logic [1:0]      htrans,
    input  logic [3*DW-1:0] hrdata_s,
    input  logic [2:0]      hready_s,
    input  logic [5:0]      hresp_s,
    output logic [2:0]      hsel,
    output logic [DW-1:0]   hrdata,
    output logic            hready,
    output logic [1:0]      hresp
);

    localparam int unsigned WDOG_W    = 5;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        (TIMEOUT == 0) ? '0 : WDOG_W'(TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        DSEL_NONE, DSEL_S0, DSEL_S1, DSEL_S2, DSEL_DEF
    } dsel_t;

    typedef enum logic [1:0] {
        ERR_IDLE, ERR_ERR1, ERR_ERR2
    } err_t;

    dsel_t             dsel;
    dsel_t             addr_tgt;
    err_t              err;
    logic [WDOG_W-1:0] wdog;

    logic              slv_active;
    logic              slv_hready;
    logic [1:0]        slv_hresp;
    logic [DW-1:0]     slv_rdata;
    logic              load_def;
    logic              wdog_fire;

    // Only the region bits of the address and the NONSEQ/SEQ bit matter here.
    logic unused_ok;
    assign unused_ok = ^{haddr_mux_out[29:0], htrans[0]};

    // Address-phase decode; deliberately not qualified by htrans.
    always_comb begin
        hsel     = 3'b000;
        addr_tgt = DSEL_DEF;
        case (haddr_mux_out[31:30])
            2'b00: begin hsel = 3'b001; addr_tgt = DSEL_S0; end
            2'b01: begin hsel = 3'b010; addr_tgt = DSEL_S1; end
            2'b10: begin hsel = 3'b100; addr_tgt = DSEL_S2; end
            default: ;
        endcase
    end

    // Response of the slave owning the current data phase.
    always_comb begin
        slv_active = 1'b0;
        slv_hready = 1'b1;
        slv_hresp  = RESP_OKAY;
        slv_rdata  = '0;
        case (dsel)
            DSEL_S0: begin
                slv_active = 1'b1;
                slv_hready = hready_s[0];
                slv_hresp  = hresp_s[1:0];
                slv_rdata  = hrdata_s[0*DW +: DW];
            end
            DSEL_S1: begin
                slv_active = 1'b1;
                slv_hready = hready_s[1];
                slv_hresp  = hresp_s[3:2];
                slv_rdata  = hrdata_s[1*DW +: DW];
            end
            DSEL_S2: begin
                slv_active = 1'b1;
                slv_hready = hready_s[2];
                slv_hresp  = hresp_s[5:4];
                slv_rdata  = hrdata_s[2*DW +: DW];
            end
            default: ;
        endcase
    end

    // The error sequence overrides whatever the data-phase select points at.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = RESP_OKAY;
        case (err)
            ERR_ERR1: begin
                hready = 1'b0;
                hresp  = RESP_ERROR;
            end
            ERR_ERR2: hresp = RESP_ERROR;
            default: begin
                if (slv_active) begin
                    hrdata = slv_rdata;
                    hready = slv_hready;
                    hresp  = slv_hresp;
                end
            end
        endcase
    end

    assign load_def  = hready && htrans[1] && (addr_tgt == DSEL_DEF);
    // A slave raising hready in the firing cycle wins over the watchdog.
    assign wdog_fire = (TIMEOUT != 0) && (err == ERR_IDLE) && slv_active &&
                       !slv_hready && (wdog == WDOG_LAST);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel <= DSEL_NONE;
            err  <= ERR_IDLE;
            wdog <= '0;
        end else begin
            if (hready) begin
                dsel <= htrans[1] ? addr_tgt : DSEL_NONE;
            end

            case (err)
                ERR_IDLE: if (wdog_fire || load_def) err <= ERR_ERR1;
                ERR_ERR1: err <= ERR_ERR2;
                ERR_ERR2: err <= load_def ? ERR_ERR1 : ERR_IDLE;
                default:  err <= ERR_IDLE;
            endcase

            if (hready || !slv_active || (err != ERR_IDLE)) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + WDOG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ahb_decoder_resp_mux.sv
// Directed bench for ahb_decoder_resp_mux: decode, data-phase routing,
// default-slave ERROR sequence, watchdog and synchronous reset.
module tb_ahb_decoder_resp_mux;

    localparam int unsigned DW = 32;

    logic            hclk = 1'b0;
    logic            hreset;
    logic [31:0]     haddr_mux_out;
    logic [1:0]      htrans;
    logic [3*DW-1:0] hrdata_s;
    logic [2:0]      hready_s;
    logic [5:0]      hresp_s;
    logic [2:0]      hsel;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic [1:0]      hresp;

    int total = 0;
    int bad   = 0;

    ahb_decoder_resp_mux #(.DW(DW), .TIMEOUT(16)) dut (
        .hclk          (hclk),
        .hreset        (hreset),
        .haddr_mux_out (haddr_mux_out),
        .htrans        (htrans),
        .hrdata_s      (hrdata_s),
        .hready_s      (hready_s),
        .hresp_s       (hresp_s),
        .hsel          (hsel),
        .hrdata        (hrdata),
        .hready        (hready),
        .hresp         (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Check the three master-facing response signals after inputs settle.
    task automatic resp(input string tag, input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
        #1;
        check({tag, "_hready"}, 64'(hready), 64'(rdy));
        check({tag, "_hresp"},  64'(hresp),  64'(rsp));
        check({tag, "_hrdata"}, 64'(hrdata), 64'(rd));
    endtask

    initial begin
        hreset        = 1'b1;
        haddr_mux_out = 32'h0;
        htrans        = 2'b00;
        hrdata_s      = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        hready_s      = 3'b111;
        hresp_s       = 6'b0;
        tick();
        tick();
        hreset = 1'b0;
        resp("por", 1'b1, 2'b00, 32'h0);

        // Reset in the middle of a slave1 wait state.
        haddr_mux_out = 32'h4000_0000;
        htrans        = 2'b10;
        hready_s      = 3'b101;
        tick();
        htrans = 2'b00;
        resp("rst_wait", 1'b0, 2'b00, 32'hDEAD_BEEF);
        hreset = 1'b1;
        tick();
        tick();
        hreset = 1'b0;
        resp("rst_after", 1'b1, 2'b00, 32'h0);
        hready_s = 3'b111;

        // Zero-wait read from slave1.
        haddr_mux_out = 32'h4000_0010;
        htrans        = 2'b10;
        #1 check("s1_hsel", 64'(hsel), 64'(3'b010));
        tick();
        htrans = 2'b00;
        resp("s1_data", 1'b1, 2'b00, 32'hDEAD_BEEF);

        // Slave2 with three wait states; a new address is held off meanwhile.
        haddr_mux_out = 32'h8000_0000;
        htrans        = 2'b10;
        hready_s      = 3'b011;
        #1 check("s2_hsel", 64'(hsel), 64'(3'b100));
        tick();
        haddr_mux_out = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            resp($sformatf("s2_wait%0d", i), 1'b0, 2'b00, 32'h2222_2222);
            if (i < 2) tick();
        end
        check("s2_hsel_busy", 64'(hsel), 64'(3'b001));
        tick();
        hready_s = 3'b111;
        resp("s2_done", 1'b1, 2'b00, 32'h2222_2222);
        tick();
        htrans = 2'b00;
        resp("s0_after_s2", 1'b1, 2'b00, 32'h1111_1111);
        tick();
        resp("idle_none", 1'b1, 2'b00, 32'h0);

        // Unmapped NONSEQ: two-cycle ERROR, then OKAY.
        haddr_mux_out = 32'hC000_0004;
        htrans        = 2'b10;
        #1 check("def_hsel", 64'(hsel), 64'(3'b000));
        tick();
        htrans = 2'b00;
        resp("def_err1", 1'b0, 2'b01, 32'h0);
        tick();
        resp("def_err2", 1'b1, 2'b01, 32'h0);
        tick();
        resp("def_okay", 1'b1, 2'b00, 32'h0);
        htrans = 2'b01;
        tick();
        resp("def_busy", 1'b1, 2'b00, 32'h0);
        htrans = 2'b00;
        tick();
        resp("def_idle", 1'b1, 2'b00, 32'h0);

        // Back-to-back unmapped transfers: four error cycles, no gap.
        htrans = 2'b11;
        tick();
        resp("b2b_err1a", 1'b0, 2'b01, 32'h0);
        tick();
        resp("b2b_err2a", 1'b1, 2'b01, 32'h0);
        tick();
        htrans = 2'b00;
        resp("b2b_err1b", 1'b0, 2'b01, 32'h0);
        tick();
        resp("b2b_err2b", 1'b1, 2'b01, 32'h0);
        tick();
        resp("b2b_okay", 1'b1, 2'b00, 32'h0);

        // Slave ERROR passes through untouched.
        haddr_mux_out = 32'h4000_0000;
        htrans        = 2'b10;
        tick();
        htrans   = 2'b00;
        hready_s = 3'b101;
        hresp_s  = 6'b00_01_00;
        resp("pass_err1", 1'b0, 2'b01, 32'hDEAD_BEEF);
        tick();
        hready_s = 3'b111;
        resp("pass_err2", 1'b1, 2'b01, 32'hDEAD_BEEF);
        tick();
        hresp_s = 6'b0;
        resp("pass_done", 1'b1, 2'b00, 32'h0);

        // Watchdog: slave0 stuck low 20 cycles, ERROR after the 16th.
        haddr_mux_out = 32'h0000_0000;
        htrans        = 2'b10;
        tick();
        htrans   = 2'b00;
        hready_s = 3'b110;
        for (int i = 1; i <= 16; i++) begin
            resp($sformatf("wd_low%0d", i), 1'b0, 2'b00, 32'h1111_1111);
            tick();
        end
        resp("wd_err1", 1'b0, 2'b01, 32'h0);
        tick();
        resp("wd_err2", 1'b1, 2'b01, 32'h0);
        tick();
        resp("wd_okay", 1'b1, 2'b00, 32'h0);
        tick();
        hready_s = 3'b111;

        // Watchdog race: slave recovers on its 16th cycle and wins.
        htrans = 2'b10;
        tick();
        htrans   = 2'b00;
        hready_s = 3'b110;
        for (int i = 1; i <= 15; i++) begin
            #1 check($sformatf("wr_low%0d", i), 64'(hready), 64'(1'b0));
            tick();
        end
        hready_s = 3'b111;
        resp("wr_recover", 1'b1, 2'b00, 32'h1111_1111);
        tick();
        resp("wr_after", 1'b1, 2'b00, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
